// File: rtl/vliw_pkg.sv
// Shared defaults and types for the VLIW register file slice.
package vliw_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 8;

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/vliw_regfile_sb_rd_port.sv
// One combinational read port: array lookup with optional write bypass and
// hardwired-zero R0. The write enables arriving here are already R0-qualified.
module rf_read_port
  import vliw_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              aluWe,
  input  logic [ADDR_W-1:0] aluWa,
  input  logic [DATA_W-1:0] aluWd,
  input  logic              memWe,
  input  logic [ADDR_W-1:0] memWa,
  input  logic [DATA_W-1:0] memWd,
  output logic [DATA_W-1:0] rdData
);

  always_comb begin
    rdData = regs[rdAddr];
    // MEM is checked first so a same-address double write returns MEM data.
    if (BYPASS) begin
      if (memWe && memWa == rdAddr)      rdData = memWd;
      else if (aluWe && aluWa == rdAddr) rdData = aluWd;
    end
    if (ZERO_R0 && rdAddr == '0) rdData = '0;
  end

endmodule

// File: rtl/vliw_regfile_sb.sv
// Two-write-lane register file with four read ports, MEM-priority write
// conflicts, sticky conflict flag and a per-register load scoreboard.
module vliw_regfile_sb
  import vliw_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_we,
  input  logic [ADDR_W-1:0]   alu_wa,
  input  logic [DATA_W-1:0]   alu_wd,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_wa,
  input  logic [DATA_W-1:0]   mem_wd,
  input  logic [ADDR_W-1:0]   alu_rm,
  input  logic [ADDR_W-1:0]   alu_rn,
  input  logic [ADDR_W-1:0]   mem_rn,
  input  logic [ADDR_W-1:0]   mem_rd,
  output logic [DATA_W-1:0]   alu_reg_rm,
  output logic [DATA_W-1:0]   alu_reg_rn,
  output logic [DATA_W-1:0]   mem_reg_rn,
  output logic [DATA_W-1:0]   mem_reg_rd,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_rd,
  output logic                alu_stall,
  output logic [NUM_REGS-1:0] busy,
  output logic                wr_conflict
);

  logic [DATA_W-1:0]   regFile [NUM_REGS];
  logic [NUM_REGS-1:0] busyQ;
  logic                wrConflictQ;
  logic                aluWeEff;
  logic                memWeEff;
  logic                ldIssueEff;
  logic                sameAddr;

  // With ZERO_R0, anything aimed at R0 is dropped before it reaches state.
  assign aluWeEff   = alu_we   && !(ZERO_R0 && alu_wa == '0);
  assign memWeEff   = mem_we   && !(ZERO_R0 && mem_wa == '0);
  assign ldIssueEff = ld_issue && !(ZERO_R0 && ld_rd == '0);
  assign sameAddr   = aluWeEff && memWeEff && (alu_wa == mem_wa);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      if (aluWeEff && !sameAddr) regFile[alu_wa] <= alu_wd;
      if (memWeEff)              regFile[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        wrConflictQ <= 1'b0;
    else if (sameAddr) wrConflictQ <= 1'b1;
  end

  // A new load to a register supersedes a writeback landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyQ <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (ldIssueEff && ld_rd == ADDR_W'(i))   busyQ[i] <= 1'b1;
        else if (mem_we && mem_wa == ADDR_W'(i)) busyQ[i] <= 1'b0;
      end
    end
  end

  assign busy        = busyQ;
  assign wr_conflict = wrConflictQ;
  assign alu_stall   = busyQ[alu_rm] | busyQ[alu_rn];

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                 .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) uAluRm (
    .rdAddr(alu_rm), .regs(regFile),
    .aluWe(aluWeEff), .aluWa(alu_wa), .aluWd(alu_wd),
    .memWe(memWeEff), .memWa(mem_wa), .memWd(mem_wd),
    .rdData(alu_reg_rm)
  );

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                 .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) uAluRn (
    .rdAddr(alu_rn), .regs(regFile),
    .aluWe(aluWeEff), .aluWa(alu_wa), .aluWd(alu_wd),
    .memWe(memWeEff), .memWa(mem_wa), .memWd(mem_wd),
    .rdData(alu_reg_rn)
  );

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                 .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) uMemRn (
    .rdAddr(mem_rn), .regs(regFile),
    .aluWe(aluWeEff), .aluWa(alu_wa), .aluWd(alu_wd),
    .memWe(memWeEff), .memWa(mem_wa), .memWd(mem_wd),
    .rdData(mem_reg_rn)
  );

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                 .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) uMemRd (
    .rdAddr(mem_rd), .regs(regFile),
    .aluWe(aluWeEff), .aluWa(alu_wa), .aluWd(alu_wd),
    .memWe(memWeEff), .memWa(mem_wa), .memWd(mem_wd),
    .rdData(mem_reg_rd)
  );

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed bench for vliw_regfile_sb: three shared-stimulus instances
// (bypass on, bypass off, zero-R0) checked against hand-computed values.
module tb_vliw_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_we, mem_we, ld_issue;
  logic [2:0]  alu_wa, mem_wa, alu_rm, alu_rn, mem_rn, mem_rd, ld_rd;
  logic [31:0] alu_wd, mem_wd;

  logic [31:0] aRm, aRn, aMn, aMd, bRm, bRn, bMn, bMd, zRm, zRn, zMn, zMd;
  logic        aStall, bStall, zStall, aConf, bConf, zConf;
  logic [7:0]  aBusy, bBusy, zBusy;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  vliw_regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b0)) dutA (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm(alu_rm), .alu_rn(alu_rn), .mem_rn(mem_rn), .mem_rd(mem_rd),
    .alu_reg_rm(aRm), .alu_reg_rn(aRn), .mem_reg_rn(aMn), .mem_reg_rd(aMd),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .alu_stall(aStall), .busy(aBusy), .wr_conflict(aConf)
  );

  vliw_regfile_sb #(.BYPASS(1'b0), .ZERO_R0(1'b0)) dutB (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm(alu_rm), .alu_rn(alu_rn), .mem_rn(mem_rn), .mem_rd(mem_rd),
    .alu_reg_rm(bRm), .alu_reg_rn(bRn), .mem_reg_rn(bMn), .mem_reg_rd(bMd),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .alu_stall(bStall), .busy(bBusy), .wr_conflict(bConf)
  );

  vliw_regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b1)) dutZ (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm(alu_rm), .alu_rn(alu_rn), .mem_rn(mem_rn), .mem_rd(mem_rd),
    .alu_reg_rm(zRm), .alu_reg_rn(zRn), .mem_reg_rn(zMn), .mem_reg_rd(zMd),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .alu_stall(zStall), .busy(zBusy), .wr_conflict(zConf)
  );

  task automatic idleInputs();
    alu_we = 0; alu_wa = 0; alu_wd = 0;
    mem_we = 0; mem_wa = 0; mem_wd = 0;
    ld_issue = 0; ld_rd = 0;
    alu_rm = 0; alu_rn = 0; mem_rn = 0; mem_rd = 0;
  endtask

  // Stimulus always changes at posedge+1; reset pulse stays clear of edges.
  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    alu_we = 1; alu_wa = 1; alu_wd = 32'h5;
    mem_we = 1; mem_wa = 7; mem_wd = 32'h77;
    ld_issue = 1; ld_rd = 6;
    step();
    alu_we = 1; alu_wa = 7; alu_wd = 32'h1;
    mem_we = 1; mem_wa = 7; mem_wd = 32'h2;
    ld_issue = 0;
    step();
    alu_we = 0; mem_we = 0;
    alu_rm = 1; alu_rn = 6; mem_rn = 7; mem_rd = 7;
    #1;
    nChecks++; if (aConf !== 1'b1)     begin nFails++; $display("FAIL rst_pre_conf: got %b want 1", aConf); end
    nChecks++; if (aBusy !== 8'h40)    begin nFails++; $display("FAIL rst_pre_busy: got %h want 40", aBusy); end
    nChecks++; if (aRm !== 32'h5)      begin nFails++; $display("FAIL rst_pre_r1: got %h want 5", aRm); end
    reset = 1'b0;
    #1;
    nChecks++; if (aRm !== 32'h0)      begin nFails++; $display("FAIL rst_rm: got %h want 0", aRm); end
    nChecks++; if (aRn !== 32'h0)      begin nFails++; $display("FAIL rst_rn: got %h want 0", aRn); end
    nChecks++; if (aMn !== 32'h0)      begin nFails++; $display("FAIL rst_mrn: got %h want 0", aMn); end
    nChecks++; if (aMd !== 32'h0)      begin nFails++; $display("FAIL rst_mrd: got %h want 0", aMd); end
    nChecks++; if (aBusy !== 8'h00)    begin nFails++; $display("FAIL rst_busy: got %h want 00", aBusy); end
    nChecks++; if (aConf !== 1'b0)     begin nFails++; $display("FAIL rst_conf: got %b want 0", aConf); end
    nChecks++; if (aStall !== 1'b0)    begin nFails++; $display("FAIL rst_stall: got %b want 0", aStall); end
    #2 reset = 1'b1;
    step();
    // late writeback to the register whose load was dropped by reset
    mem_we = 1; mem_wa = 6; mem_wd = 32'h66;
    step();
    mem_we = 0; alu_rn = 6;
    #1;
    nChecks++; if (bRn !== 32'h66)     begin nFails++; $display("FAIL rst_late_wb: got %h want 66", bRn); end
    nChecks++; if (aBusy !== 8'h00)    begin nFails++; $display("FAIL rst_late_busy: got %h want 00", aBusy); end
  endtask

  task automatic test_bypass();
    doReset();
    alu_we = 1; alu_wa = 3; alu_wd = 32'hDEAD_BEEF;
    alu_rm = 3; mem_rd = 3;
    #1;
    nChecks++; if (aRm !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL byp_rm: got %h want deadbeef", aRm); end
    nChecks++; if (aMd !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL byp_mrd: got %h want deadbeef", aMd); end
    nChecks++; if (bRm !== 32'h0)         begin nFails++; $display("FAIL nobyp_old: got %h want 0", bRm); end
    step();
    alu_we = 0;
    #1;
    nChecks++; if (bRm !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL nobyp_next: got %h want deadbeef", bRm); end
    nChecks++; if (aRm !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL byp_next: got %h want deadbeef", aRm); end
  endtask

  task automatic test_conflict();
    doReset();
    alu_we = 1; alu_wa = 5; alu_wd = 32'h1;
    mem_we = 1; mem_wa = 5; mem_wd = 32'h2;
    alu_rm = 5; mem_rn = 5;
    #1;
    nChecks++; if (aRm !== 32'h2)  begin nFails++; $display("FAIL conf_byp_prio: got %h want 2", aRm); end
    nChecks++; if (bRm !== 32'h0)  begin nFails++; $display("FAIL conf_nobyp_old: got %h want 0", bRm); end
    step();
    alu_we = 0; mem_we = 0;
    #1;
    nChecks++; if (bRm !== 32'h2)  begin nFails++; $display("FAIL conf_r5: got %h want 2", bRm); end
    nChecks++; if (bMn !== 32'h2)  begin nFails++; $display("FAIL conf_r5_mrn: got %h want 2", bMn); end
    nChecks++; if (aConf !== 1'b1) begin nFails++; $display("FAIL conf_flag: got %b want 1", aConf); end
    nChecks++; if (zConf !== 1'b1) begin nFails++; $display("FAIL conf_flag_z: got %b want 1", zConf); end
    for (int i = 0; i < 10; i++) begin
      step();
      nChecks++; if (aConf !== 1'b1) begin nFails++; $display("FAIL conf_sticky[%0d]: got %b want 1", i, aConf); end
    end
    nChecks++; if (aRm !== 32'h2)  begin nFails++; $display("FAIL conf_r5_hold: got %h want 2", aRm); end
  endtask

  task automatic test_scoreboard();
    doReset();
    ld_issue = 1; ld_rd = 4;
    alu_rn = 4;
    #1;
    nChecks++; if (aStall !== 1'b0)  begin nFails++; $display("FAIL sb_c0_stall: got %b want 0", aStall); end
    step();
    ld_issue = 0;
    #1;
    nChecks++; if (aBusy !== 8'h10)  begin nFails++; $display("FAIL sb_c1_busy: got %h want 10", aBusy); end
    nChecks++; if (aStall !== 1'b1)  begin nFails++; $display("FAIL sb_c1_stall: got %b want 1", aStall); end
    // ALU write to a busy register must not release it
    alu_we = 1; alu_wa = 4; alu_wd = 32'h3;
    step();
    alu_we = 0; alu_rn = 0; alu_rm = 4;
    #1;
    nChecks++; if (aBusy !== 8'h10)  begin nFails++; $display("FAIL sb_c2_alu_wr: got %h want 10", aBusy); end
    nChecks++; if (aStall !== 1'b1)  begin nFails++; $display("FAIL sb_c2_stall_rm: got %b want 1", aStall); end
    step();
    alu_rm = 0; alu_rn = 4;
    mem_we = 1; mem_wa = 4; mem_wd = 32'h7;
    #1;
    nChecks++; if (aStall !== 1'b1)  begin nFails++; $display("FAIL sb_c3_stall: got %b want 1", aStall); end
    step();
    mem_we = 0;
    #1;
    nChecks++; if (aStall !== 1'b0)  begin nFails++; $display("FAIL sb_c4_stall: got %b want 0", aStall); end
    nChecks++; if (aBusy !== 8'h00)  begin nFails++; $display("FAIL sb_c4_busy: got %h want 00", aBusy); end
    nChecks++; if (bRn !== 32'h7)    begin nFails++; $display("FAIL sb_c4_r4: got %h want 7", bRn); end
  endtask

  task automatic test_race();
    doReset();
    ld_issue = 1; ld_rd = 2;
    step();
    ld_issue = 1; ld_rd = 2;
    mem_we = 1; mem_wa = 2; mem_wd = 32'h55;
    #1;
    nChecks++; if (aBusy !== 8'h04)  begin nFails++; $display("FAIL race_pre_busy: got %h want 04", aBusy); end
    step();
    ld_issue = 0; mem_we = 0; alu_rm = 2;
    #1;
    nChecks++; if (aBusy !== 8'h04)  begin nFails++; $display("FAIL race_busy: got %h want 04", aBusy); end
    nChecks++; if (bRm !== 32'h55)   begin nFails++; $display("FAIL race_r2: got %h want 55", bRm); end
    nChecks++; if (aStall !== 1'b1)  begin nFails++; $display("FAIL race_stall: got %b want 1", aStall); end
  endtask

  task automatic test_zero_r0();
    doReset();
    alu_we = 1; alu_wa = 0; alu_wd = 32'h9;
    mem_we = 1; mem_wa = 0; mem_wd = 32'h8;
    ld_issue = 1; ld_rd = 0;
    #1;
    nChecks++; if (zRm !== 32'h0)   begin nFails++; $display("FAIL z_byp_rm: got %h want 0", zRm); end
    nChecks++; if (zRn !== 32'h0)   begin nFails++; $display("FAIL z_byp_rn: got %h want 0", zRn); end
    nChecks++; if (zMn !== 32'h0)   begin nFails++; $display("FAIL z_byp_mrn: got %h want 0", zMn); end
    nChecks++; if (zMd !== 32'h0)   begin nFails++; $display("FAIL z_byp_mrd: got %h want 0", zMd); end
    nChecks++; if (aRm !== 32'h8)   begin nFails++; $display("FAIL nz_byp_r0: got %h want 8", aRm); end
    step();
    idleInputs();
    #1;
    nChecks++; if (zRm !== 32'h0)   begin nFails++; $display("FAIL z_r0_rm: got %h want 0", zRm); end
    nChecks++; if (zMd !== 32'h0)   begin nFails++; $display("FAIL z_r0_mrd: got %h want 0", zMd); end
    nChecks++; if (zConf !== 1'b0)  begin nFails++; $display("FAIL z_conf: got %b want 0", zConf); end
    nChecks++; if (zBusy !== 8'h00) begin nFails++; $display("FAIL z_busy: got %h want 00", zBusy); end
    nChecks++; if (aConf !== 1'b1)  begin nFails++; $display("FAIL nz_conf_r0: got %b want 1", aConf); end
    nChecks++; if (aBusy !== 8'h01) begin nFails++; $display("FAIL nz_busy_r0: got %h want 01", aBusy); end
    nChecks++; if (bRm !== 32'h8)   begin nFails++; $display("FAIL nz_r0_val: got %h want 8", bRm); end
  endtask

  initial begin
    idleInputs();
    reset = 1'b0;
    #12 reset = 1'b1;
    step();
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_race();
    test_zero_r0();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
